morse_char_queue: RTL and testbench
===================================

MORSE_CHAR_QUEUE -- requirements
Module: morse_char_queue

Interface
REQ-001 Parameter WORD_BITS, default 8, character width in bits.
REQ-002 Parameter ADDR_BITS, default 3, queue address width; depth DEPTH = 2**ADDR_BITS (8 entries).
REQ-003 clk_i  input  1  system clock (100 MHz); single clock domain.
REQ-004 reset_i  input  1  reset; synchronous, active-high.
REQ-005 rx_data_i  input  WORD_BITS  received UART byte.
REQ-006 rx_done_i  input  1  one-cycle strobe, rx_data_i valid.
REQ-007 morse_done_i  input  1  one-cycle strobe from morse generator, current character finished.
REQ-008 ascii_o  output  WORD_BITS  character presented to morse generator, registered.
REQ-009 en_o  output  1  one-cycle start strobe to morse generator, registered.
REQ-010 count_o  output  ADDR_BITS+1  entries stored (0..DEPTH).
REQ-011 empty_o  output  1  count_o == 0.
REQ-012 full_o  output  1  count_o == DEPTH.
REQ-013 overflow_o  output  1  sticky flag, a byte was dropped.

Function
REQ-014 Push: at an edge with rx_done_i=1, rx_data_i SHALL be written at the write pointer if not full, or if full and a pop occurs at the same edge.
REQ-015 Push when full with no simultaneous pop SHALL drop the byte, leave queue contents and count unchanged, and set overflow_o at that edge.
REQ-016 Pointers SHALL be ADDR_BITS wide and wrap from DEPTH-1 to 0; count_o is a separate counter: +1 on push only, -1 on pop only, unchanged on push+pop.
REQ-017 FSM states IDLE and BUSY; reset enters IDLE.
REQ-018 IDLE with count_o>0 at an edge: pop head entry into ascii_o, set en_o=1, go BUSY.
REQ-019 IDLE with count_o==0: stay IDLE, en_o=0; no same-cycle bypass -- a byte pushed at edge k is popped no earlier than edge k+1.
REQ-020 en_o SHALL be high for exactly one cycle per pop and low in all other cycles.
REQ-021 BUSY: ascii_o SHALL hold its value; on morse_done_i=1 go IDLE; the next pop occurs no earlier than the following edge.
REQ-022 morse_done_i while IDLE SHALL be ignored.
REQ-023 Push and pop at the same edge with count_o==DEPTH: count_o stays DEPTH, the new byte is stored, and the popped byte is the oldest entry.
REQ-024 Characters SHALL be issued in arrival order, with no duplication or loss except as specified in REQ-015.

Reset
REQ-025 With reset_i=1 at an edge: state=IDLE, pointers=0, count_o=0, ascii_o=0, en_o=0, overflow_o=0; empty_o=1, full_o=0.
REQ-026 Reset SHALL take priority over rx_done_i and morse_done_i at the same edge; a reset during BUSY discards queued data and the in-flight character.
REQ-027 Storage array contents need not be cleared by reset.

Configuration
REQ-028 Macro MORSE_QUEUE_UPCASE_EN: when defined, bytes 0x61..0x7A SHALL be stored as the value minus 0x20, and all other bytes unchanged.
REQ-029 When MORSE_QUEUE_UPCASE_EN is undefined, bytes SHALL be stored unmodified.

Verification
REQ-030 Reset, then push 0x53 at edge k -> en_o=1 and ascii_o=0x53 for one cycle after edge k+1; count_o back to 0.
REQ-031 Push 0x53,0x4F,0x53 back-to-back with morse_done_i pulsed 10 cycles after each en_o -> three en_o pulses in order 0x53,0x4F,0x53, each issued after the prior morse_done_i.
REQ-032 Hold BUSY, push 9 bytes -> full_o=1 after the 8th, 9th dropped, overflow_o=1 and sticky, count_o=8.
REQ-033 With queue full, rx_done_i and a pop (IDLE after morse_done_i) at the same edge -> new byte accepted, count_o stays 8, overflow_o stays 0.
REQ-034 Push 0x61 -> ascii_o=0x41 with MORSE_QUEUE_UPCASE_EN defined, 0x61 without it.
REQ-035 Assert reset_i during BUSY with 3 entries queued -> next cycle count_o=0, en_o=0, empty_o=1, and no further en_o until a new push.

Source files
------------

// File: rtl/morse_char_queue.sv
// morse_char_queue: 8-deep FIFO feeding received characters one at a time to a morse generator.
// Optional MORSE_QUEUE_UPCASE_EN folds lowercase ASCII to uppercase on entry.
module morse_char_queue #(
  parameter int WORD_BITS = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [WORD_BITS-1:0] rx_data_i,
  input  logic                 rx_done_i,
  input  logic                 morse_done_i,
  output logic [WORD_BITS-1:0] ascii_o,
  output logic                 en_o,
  output logic [ADDR_BITS:0]   count_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 overflow_o
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [WORD_BITS-1:0] din;
  logic pop, push;
  assign empty_o = count_o == '0;
  assign full_o  = count_o == (ADDR_BITS+1)'(DEPTH);
  assign pop     = state_q == IDLE && !empty_o;
  // a full queue still accepts a byte when the head leaves at the same edge
  assign push    = rx_done_i && (!full_o || pop);
  always_comb begin
`ifdef MORSE_QUEUE_UPCASE_EN
    din = (rx_data_i >= WORD_BITS'(8'h61) && rx_data_i <= WORD_BITS'(8'h7A)) ? rx_data_i - WORD_BITS'(8'h20) : rx_data_i;
`else
    din = rx_data_i;
`endif
  end
  always_comb begin
    state_d = state_q;
    if (pop) state_d = BUSY;
    else if (state_q == BUSY && morse_done_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i) if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      ascii_o    <= '0;
      en_o       <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state_q <= state_d;
      en_o    <= pop;
      if (push) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_BITS'(1);
        ascii_o <= mem[rd_ptr];
      end
      count_o <= (push && !pop) ? count_o + (ADDR_BITS+1)'(1) :
                 (!push && pop) ? count_o - (ADDR_BITS+1)'(1) : count_o;
      if (rx_done_i && !push) overflow_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_morse_char_queue.sv
// tb_morse_char_queue: directed checks of ordering, full/overflow, upcase option and reset for morse_char_queue.
module tb_morse_char_queue;
  logic clk = 1'b0;
  logic reset_i = 1'b1, rx_done_i = 1'b0, morse_done_i = 1'b0;
  logic [7:0] rx_data_i = '0, ascii_o;
  logic en_o, empty_o, full_o, overflow_o;
  logic [3:0] count_o;
  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_up;

  morse_char_queue dut (
    .clk_i(clk), .reset_i(reset_i), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
    .morse_done_i(morse_done_i), .ascii_o(ascii_o), .en_o(en_o), .count_o(count_o),
    .empty_o(empty_o), .full_o(full_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    rx_done_i = 1'b1;
    rx_data_i = d;
    step();
    rx_done_i = 1'b0;
  endtask

  task automatic done_pulse();
    morse_done_i = 1'b1;
    step();
    morse_done_i = 1'b0;
  endtask

  initial begin
    rx_done_i = 1'b1;
    rx_data_i = 8'h77;
    step();
    step();
    rx_done_i = 1'b0;
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_en", en_o, 0);
    chk("rst_ascii", ascii_o, 0);
    chk("rst_ovf", overflow_o, 0);
    reset_i = 1'b0;
    done_pulse();
    chk("idle_done_ignored_en", en_o, 0);
    // single character: no bypass, pop one edge after the push
    push(8'h53);
    chk("push1_count", count_o, 1);
    chk("push1_no_bypass", en_o, 0);
    step();
    chk("pop1_en", en_o, 1);
    chk("pop1_ascii", ascii_o, 8'h53);
    chk("pop1_count", count_o, 0);
    step();
    chk("busy_en_low", en_o, 0);
    chk("busy_ascii_hold", ascii_o, 8'h53);
    done_pulse();
    // three back-to-back bytes, morse_done_i 10 cycles after each en_o
    push(8'h53);
    push(8'h4F);
    chk("sos0_en", en_o, 1);
    chk("sos0_ascii", ascii_o, 8'h53);
    push(8'h53);
    chk("sos_count", count_o, 2);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("sos_wait_en", en_o, 0);
    end
    done_pulse();
    chk("sos_done_edge_en", en_o, 0);
    step();
    chk("sos1_en", en_o, 1);
    chk("sos1_ascii", ascii_o, 8'h4F);
    for (int i = 0; i < 9; i++) step();
    done_pulse();
    step();
    chk("sos2_en", en_o, 1);
    chk("sos2_ascii", ascii_o, 8'h53);
    chk("sos2_count", count_o, 0);
    done_pulse();
    // fill while busy, then push+pop at full
    push(8'h41);
    step();
    chk("fill_busy_en", en_o, 1);
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    chk("fill_count", count_o, 8);
    chk("fill_full", full_o, 1);
    chk("fill_ovf", overflow_o, 0);
    done_pulse();
    push(8'h38);
    chk("fullpp_en", en_o, 1);
    chk("fullpp_ascii", ascii_o, 8'h30);
    chk("fullpp_count", count_o, 8);
    chk("fullpp_ovf", overflow_o, 0);
    push(8'h39);
    chk("drop_count", count_o, 8);
    chk("drop_ovf", overflow_o, 1);
    step();
    chk("ovf_sticky", overflow_o, 1);
    for (int i = 0; i < 8; i++) begin
      done_pulse();
      step();
      chk("drain_en", en_o, 1);
      chk("drain_ascii", ascii_o, 8'h31 + 8'(i));
    end
    chk("drain_empty", empty_o, 1);
    chk("drain_ovf_sticky", overflow_o, 1);
    done_pulse();
    // upcase option
`ifdef MORSE_QUEUE_UPCASE_EN
    exp_up = 8'h41;
`else
    exp_up = 8'h61;
`endif
    push(8'h61);
    step();
    chk("upcase_ascii", ascii_o, exp_up);
    done_pulse();
    push(8'h7B);
    step();
    chk("upcase_boundary", ascii_o, 8'h7B);
    done_pulse();
    // reset during busy with 3 queued
    push(8'h41);
    step();
    push(8'h42);
    push(8'h43);
    push(8'h44);
    chk("prerst_count", count_o, 3);
    reset_i = 1'b1;
    morse_done_i = 1'b1;
    step();
    reset_i = 1'b0;
    morse_done_i = 1'b0;
    chk("busyrst_count", count_o, 0);
    chk("busyrst_en", en_o, 0);
    chk("busyrst_empty", empty_o, 1);
    chk("busyrst_ovf", overflow_o, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst_en", en_o, 0);
    end
    push(8'h45);
    step();
    chk("postrst_en_new", en_o, 1);
    chk("postrst_ascii", ascii_o, 8'h45);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
